// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter on the CPU IO-port bus.
// CPU writes to BASE_ADDR are queued in a small FIFO and sent 8N1, LSB first,
// on tx. BASE_ADDR+1 is a read-only status register:
//    {4'b0, parity_en, overflow, busy, full}
// Reading status clears the sticky overflow flag.
//
// Build option: define IO_UART_TX_PARITY_EN to add an even-parity bit after
// the data bits (frame becomes 11 bit times, status bit 3 reads 1).
//
// Ports:
//    clk   system clock, rising edge
//    rst   synchronous active-high reset
//    addr  bus address
//    RE    bus read strobe
//    WE    bus write strobe
//    Din   bus write data
//    Dout  bus read data (combinational, 0 unless status is read)
//    sel   addr hits the data or status register
//    tx    serial output, idle high, registered
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | line high; pops the FIFO head as soon as count!=0
// START  | start bit (low) for CLK_DIV cycles
// DATA   | 8 data bits, LSB first, CLK_DIV cycles each
// PARITY | even parity bit (only with IO_UART_TX_PARITY_EN)
// STOP   | stop bit (high) for CLK_DIV cycles
module io_uart_tx #(
   parameter logic [7:0]  BASE_ADDR  = 8'h08,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   input  logic       RE,
   input  logic       WE,
   input  logic [7:0] Din,
   output logic [7:0] Dout,
   output logic       sel,
   output logic       tx
);

   localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW        = AW + 1;
   localparam logic [7:0]    STAT_ADDR = BASE_ADDR + 8'd1;
   localparam logic [15:0]   BAUD_LOAD = 16'(CLK_DIV - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
`ifdef IO_UART_TX_PARITY_EN
   localparam logic          PAR_FLAG  = 1'b1;
`else
   localparam logic          PAR_FLAG  = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            overflow;
   logic [7:0]      shift_reg;
   logic [15:0]     baud_cnt;
   logic [2:0]      bit_idx;
`ifdef IO_UART_TX_PARITY_EN
   logic            par_bit;
`endif

   logic data_hit;
   logic stat_hit;
   logic push;
   logic stat_rd;
   logic full;
   logic pop;
   logic accept;
   logic busy;

   assign data_hit = (addr == BASE_ADDR);
   assign stat_hit = (addr == STAT_ADDR);
   assign sel      = data_hit | stat_hit;
   assign push     = WE & data_hit;
   assign stat_rd  = RE & stat_hit;
   assign full     = (count == FULL_CNT);
   assign pop      = (state == S_IDLE) & (count != '0);
   // a same-cycle pop frees the head slot, so a push into a full FIFO still fits
   assign accept   = push & (~full | pop);
   assign busy     = (state != S_IDLE) | (count != '0);

   always_comb begin
      Dout = 8'h00;
      if (stat_rd) begin
         Dout = {4'b0000, PAR_FLAG, overflow, busy, full};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= Din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // set wins over the clear from a simultaneous status read
         if (push & full & ~pop) begin
            overflow <= 1'b1;
         end else if (stat_rd) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tx        <= 1'b1;
         shift_reg <= 8'h00;
         baud_cnt  <= 16'd0;
         bit_idx   <= 3'd0;
`ifdef IO_UART_TX_PARITY_EN
         par_bit   <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (pop) begin
                  shift_reg <= mem[rd_ptr];
`ifdef IO_UART_TX_PARITY_EN
                  par_bit   <= ^mem[rd_ptr];
`endif
                  baud_cnt  <= BAUD_LOAD;
                  bit_idx   <= 3'd0;
                  tx        <= 1'b0;
                  state     <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= BAUD_LOAD;
                  tx       <= shift_reg[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= BAUD_LOAD;
                  if (bit_idx == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                     tx    <= par_bit;
                     state <= S_PARITY;
`else
                     tx    <= 1'b1;
                     state <= S_STOP;
`endif
                  end else begin
                     tx        <= shift_reg[1];
                     shift_reg <= shift_reg >> 1;
                     bit_idx   <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`ifdef IO_UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= BAUD_LOAD;
                  tx       <= 1'b1;
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (baud_cnt == 16'd0) begin
                  tx    <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a queue-and-elapsed-time model of the transmitter is
// compared against the DUT every cycle, plus directed scenarios with literal
// expectations and a randomized bus-traffic phase.
module tb_io_uart_tx;

   localparam logic [7:0] DATA_A = 8'h08;
   localparam logic [7:0] STAT_A = 8'h09;
   localparam int CD    = 4;
   localparam int DEPTH = 4;
`ifdef IO_UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = (10 + PAR) * CD;
   localparam int P8 = PAR * 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] addr = 8'h00;
   logic       RE = 1'b0;
   logic       WE = 1'b0;
   logic [7:0] Din = 8'h00;
   logic [7:0] Dout;
   logic       sel;
   logic       tx;

   int checks = 0;
   int failures = 0;

   io_uart_tx #(.BASE_ADDR(DATA_A), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .addr(addr), .RE(RE), .WE(WE),
      .Din(Din), .Dout(Dout), .sel(sel), .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] q[$];
   logic [7:0] cur = 8'h00;
   logic       m_ov = 1'b0;
   bit         in_frame = 0;
   bit         mvalid = 0;
   int         cyc = 0;
   int         fstart = 0;
   bit         m_push, m_rd, m_full, m_pop;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         m_ov     = 1'b0;
         in_frame = 0;
         mvalid   = 1;
      end else begin
         m_push = WE && (addr == DATA_A);
         m_rd   = RE && (addr == STAT_A);
         m_full = (q.size() == DEPTH);
         m_pop  = 0;
         if (in_frame) begin
            if (cyc - fstart == FL) in_frame = 0;
         end else if (q.size() != 0) begin
            m_pop    = 1;
            cur      = q.pop_front();
            in_frame = 1;
            fstart   = cyc;
         end
         if (m_push && (!m_full || m_pop)) q.push_back(Din);
         if (m_push && m_full && !m_pop) m_ov = 1'b1;
         else if (m_rd) m_ov = 1'b0;
      end
   end

   function automatic int exp_tx();
      int j;
      if (!in_frame) return 1;
      j = (cyc - fstart) / CD;
      if (j == 0) return 0;
      if (j <= 8) return int'(cur[j-1]);
      if (PAR == 1 && j == 9) return int'(^cur);
      return 1;
   endfunction

   function automatic int exp_dout();
      int busy_m, full_m;
      if (!(RE && addr == STAT_A)) return 0;
      busy_m = (in_frame || q.size() != 0) ? 1 : 0;
      full_m = (q.size() == DEPTH) ? 1 : 0;
      return P8 + int'(m_ov) * 4 + busy_m * 2 + full_m;
   endfunction

   always @(negedge clk) begin
      if (mvalid) begin
         chk("cyc_tx", int'(tx), exp_tx());
         chk("cyc_sel", int'(sel), int'((addr == DATA_A) || (addr == STAT_A)));
         chk("cyc_dout", int'(Dout), exp_dout());
      end
   end

   // ---------------- stimulus ----------------
   int rec_tx [0:127];
   int rec_do [0:127];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // write d at edge 0, then poll status and record cycles 0..n
   task automatic wr_rec(input logic [7:0] d, input int n);
      addr = DATA_A; Din = d; WE = 1'b1; RE = 1'b0;
      tick();
      WE = 1'b0; addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      rec_tx[0] = int'(tx); rec_do[0] = int'(Dout);
      for (int c = 1; c <= n; c++) begin
         tick();
         @(negedge clk);
         rec_tx[c] = int'(tx); rec_do[c] = int'(Dout);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int zeros;
      wait_n(3);
      rst = 1'b0;
      addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      chk("reset_status", int'(Dout), P8);
      chk("reset_tx", int'(tx), 1);
      RE = 1'b0;
      tick();

      // register decode
      addr = DATA_A; RE = 1'b1;
      @(negedge clk);
      chk("data_read_zero", int'(Dout), 0);
      chk("sel_data", int'(sel), 1);
      addr = 8'h07;
      #1;
      chk("sel_gpio", int'(sel), 0);
      RE = 1'b0;
      tick();

      // T1: 0xA5 frame shape
      wr_rec(8'hA5, FL + 1);
      chk("t1_c0_idle", rec_tx[0], 1);
      chk("t1_c0_busy", rec_do[0], P8 + 2);
      chk("t1_start1", rec_tx[1], 0);
      chk("t1_start4", rec_tx[4], 0);
      chk("t1_bit0", rec_tx[5], 1);
      chk("t1_bit1", rec_tx[9], 0);
      chk("t1_bit3", rec_tx[17], 0);
      chk("t1_bit5", rec_tx[25], 1);
      chk("t1_bit7", rec_tx[33], 1);
      chk("t1_c37", rec_tx[37], (PAR == 1) ? 0 : 1);
      chk("t1_stop_end", rec_tx[FL], 1);
      chk("t1_busy_last", rec_do[FL], P8 + 2);
      chk("t1_idle_status", rec_do[FL + 1], P8);
      RE = 1'b0;
      tick();

      // T2: 5 accepted, 4 dropped, overflow sticky until read
      addr = DATA_A; WE = 1'b1;
      for (int i = 0; i < 9; i++) begin
         Din = 8'($urandom);
         tick();
      end
      WE = 1'b0; addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      chk("t2_status_ovf", int'(Dout), P8 + 7);
      tick();
      @(negedge clk);
      chk("t2_status_clr", int'(Dout), P8 + 3);
      RE = 1'b0;
      wait_n(5 * (FL + 1) + 4);

      // T3: 0x00 then 0xFF back to back
      addr = DATA_A; WE = 1'b1; Din = 8'h00;
      tick();
      Din = 8'hFF;
      tick();
      WE = 1'b0; addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      rec_tx[1] = int'(tx); rec_do[1] = int'(Dout);
      for (int c = 2; c <= 2 * FL + 2; c++) begin
         tick();
         @(negedge clk);
         rec_tx[c] = int'(tx); rec_do[c] = int'(Dout);
      end
      chk("t3_start", rec_tx[1], 0);
      chk("t3_zero_bit7", rec_tx[36], 0);
      chk("t3_stop1", rec_tx[FL], 1);
      chk("t3_gap", rec_tx[FL + 1], 1);
      chk("t3_start2", rec_tx[FL + 2], 0);
      chk("t3_start2_end", rec_tx[FL + 5], 0);
      chk("t3_ff_bit0", rec_tx[FL + 6], 1);
      chk("t3_stop2", rec_tx[2 * FL + 1], 1);
      chk("t3_busy_end", rec_do[2 * FL + 1], P8 + 2);
      chk("t3_idle_after", rec_do[2 * FL + 2], P8);
      RE = 1'b0;
      tick();

      // T4: reset during data bit 3 of 0x3C
      addr = DATA_A; WE = 1'b1; Din = 8'h3C;
      tick();
      WE = 1'b0; addr = STAT_A; RE = 1'b1;
      wait_n(18);
      @(negedge clk);
      chk("t4_bit3", int'(tx), 1);
      chk("t4_busy", int'(Dout), P8 + 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t4_tx_after_rst", int'(tx), 1);
      chk("t4_status_after_rst", int'(Dout), P8);
      zeros = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         @(negedge clk);
         if (tx == 1'b0) zeros++;
      end
      chk("t4_no_restart", zeros, 0);
      RE = 1'b0;
      tick();

      // T5: push into full FIFO on the IDLE pop edge
      addr = DATA_A; WE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Din = 8'($urandom);
         tick();
      end
      WE = 1'b0;
      wait_n(FL - 3);
      addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      chk("t5_full_in_idle", int'(Dout), P8 + 3);
      chk("t5_idle_tx", int'(tx), 1);
      RE = 1'b0; addr = DATA_A; WE = 1'b1; Din = 8'h5A;
      tick();
      WE = 1'b0; addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      chk("t5_after_push", int'(Dout), P8 + 3);
      chk("t5_new_start", int'(tx), 0);
      RE = 1'b0;
      wait_n(5 * (FL + 1) + 4);

      // T6: 0x07 (odd weight -> parity bit 1 when enabled)
      wr_rec(8'h07, FL + 1);
      chk("t6_bit2", rec_tx[13], 1);
      chk("t6_bit7", rec_tx[33], 0);
      chk("t6_c37", rec_tx[37], 1);
      chk("t6_busy_last", rec_do[FL], P8 + 2);
      chk("t6_par_flag", (rec_do[FL + 1] >> 3) & 1, PAR);
      chk("t6_idle", rec_do[FL + 1], P8);
      RE = 1'b0;
      tick();

      // randomized bus traffic
      for (int blk = 0; blk < 8; blk++) begin
         int wp;
         wp = (blk % 4) * 10 + 2;
         for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            addr = (r < 4) ? DATA_A : (r < 7) ? STAT_A : 8'($urandom_range(0, 255));
            WE   = (int'($urandom_range(0, 99)) < wp);
            RE   = 1'($urandom_range(0, 1));
            Din  = 8'($urandom);
            rst  = ($urandom_range(0, 999) == 0);
            tick();
         end
      end
      rst = 1'b0; WE = 1'b0; RE = 1'b0;
      wait_n(6 * (FL + 1));
      addr = STAT_A; RE = 1'b1;
      @(negedge clk);
      chk("final_idle", int'(Dout) & 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
